mem_arbiter: RTL and testbench

- Two-master arbiter for the single-port synchronous data memory behind the rv32 core.
- Master 0 is the core load/store port. Master 1 is the UART boot-loader/debug port.
- Grants one access per cycle, supports locked multi-beat ownership, and returns read data one cycle after the access.
- Sits between the core/UART loader and the data memory instance, inside the risc_v top.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter_arb_pick.sv | 43 ++++
 rtl/mem_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared types and constants for the two-master data-memory arbiter.
//   arb_state_t : ownership state (IDLE, OWN0, OWN1)
//   mem_req_t   : one memory access (we, addr, wdata, be) at default widths
//   BE_W        : byte-enable width for the default data width
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W       = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [BE_W-1:0]       be;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both master request/response channels and the
// memory-side bus of the arbiter.
//   slave  : arbiter view (takes m*_req/lock/we/addr/wdata/be and mem_rdata,
//            drives m*_gnt/rvalid/rdata and mem_en/we/addr/wdata/be)
//   master : requester/memory view (the mirror image)
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                  m0_req, m0_lock, m0_we;
  logic [ADDR_W-1:0]     m0_addr;
  logic [DATA_W-1:0]     m0_wdata;
  logic [DATA_W/8-1:0]   m0_be;
  logic                  m0_gnt, m0_rvalid;
  logic [DATA_W-1:0]     m0_rdata;

  logic                  m1_req, m1_lock, m1_we;
  logic [ADDR_W-1:0]     m1_addr;
  logic [DATA_W-1:0]     m1_wdata;
  logic [DATA_W/8-1:0]   m1_be;
  logic                  m1_gnt, m1_rvalid;
  logic [DATA_W-1:0]     m1_rdata;

  logic                  mem_en, mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata, m0_be,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_be,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_lock, m0_we, m0_addr, m0_wdata, m0_be,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_be,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// arb_pick: combinational grant selection for the two-master arbiter.
//   req[1:0]   : request per master
//   state      : current ownership state
//   last_grant : master granted most recently (round-robin tie-break only)
//   gnt[1:0]   : one-hot grant (or zero)
// Optional feature: MEM_ARB_ROUND_ROBIN_EN makes IDLE ties go to the master
// that was not granted last; otherwise master 0 always wins ties.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_state_t state,
  input  logic       last_grant,
  output logic [1:0] gnt
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

  // Owner-only grant while locked; priority / round-robin when idle.
  always_comb begin
    gnt = 2'b00;
    case (state)
      OWN0: gnt = {1'b0, req[0]};
      OWN1: gnt = {req[1], 1'b0};
      IDLE: begin
        if (req == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          gnt = last_grant ? 2'b01 : 2'b10;
`else
          gnt = 2'b01;
`endif
        end else begin
          gnt = req;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master arbiter for the single-port synchronous data memory.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mem_arbiter_if.slave -- m0 (core LSU) and m1 (UART loader)
//              request/response channels plus the memory-side bus
// Grants one access per cycle in the same cycle as the request, supports
// locked multi-beat ownership and returns read data one cycle after access.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int BEW = DATA_W / 8;

  arb_state_t        state_r, state_s;
  logic              last_grant_r;
  logic [1:0]        rvalid_r;
  logic [1:0]        req_s, pick_s, gnt_s;
  logic              sel_we_s, sel_lock_s;
  logic [ADDR_W-1:0] sel_addr_s, hold_addr_r;
  logic [DATA_W-1:0] sel_wdata_s, hold_wdata_r;
  logic [BEW-1:0]    sel_be_s, hold_be_r;

  assign req_s = {bus.m1_req, bus.m0_req};

  arb_pick u_pick (
    .req        (req_s),
    .state      (state_r),
    .last_grant (last_grant_r),
    .gnt        (pick_s)
  );

  // Nothing is granted (and nothing reaches memory) in a reset cycle.
  assign gnt_s = rst ? 2'b00 : pick_s;

  // Route the granted master's payload; hold the last payload when idle.
  always_comb begin
    sel_we_s    = 1'b0;
    sel_lock_s  = 1'b0;
    sel_addr_s  = hold_addr_r;
    sel_wdata_s = hold_wdata_r;
    sel_be_s    = hold_be_r;
    if (gnt_s[1]) begin
      sel_we_s    = bus.m1_we;
      sel_lock_s  = bus.m1_lock;
      sel_addr_s  = bus.m1_addr;
      sel_wdata_s = bus.m1_wdata;
      sel_be_s    = bus.m1_be;
    end else if (gnt_s[0]) begin
      sel_we_s    = bus.m0_we;
      sel_lock_s  = bus.m0_lock;
      sel_addr_s  = bus.m0_addr;
      sel_wdata_s = bus.m0_wdata;
      sel_be_s    = bus.m0_be;
    end else begin
      sel_we_s    = 1'b0;
      sel_lock_s  = 1'b0;
    end
  end

  // Next ownership state; an owner that stops requesting releases its lock.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_s[0]) begin
          state_s = sel_lock_s ? OWN0 : IDLE;
        end else if (gnt_s[1]) begin
          state_s = sel_lock_s ? OWN1 : IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      OWN0: begin
        if (gnt_s[0]) begin
          state_s = sel_lock_s ? OWN0 : IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      OWN1: begin
        if (gnt_s[1]) begin
          state_s = sel_lock_s ? OWN1 : IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, last grant, read-return owner and held payload registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      rvalid_r     <= 2'b00;
      hold_addr_r  <= '0;
      hold_wdata_r <= '0;
      hold_be_r    <= '0;
    end else begin
      state_r  <= state_s;
      rvalid_r <= gnt_s & {2{~sel_we_s}};
      if (gnt_s != 2'b00) begin
        last_grant_r <= gnt_s[1];
        hold_addr_r  <= sel_addr_s;
        hold_wdata_r <= sel_wdata_s;
        hold_be_r    <= sel_be_s;
      end
    end
  end

  assign bus.m0_gnt    = gnt_s[0];
  assign bus.m1_gnt    = gnt_s[1];
  // A read return still in flight when reset hits is dropped immediately.
  assign bus.m0_rvalid = rvalid_r[0] & ~rst;
  assign bus.m1_rvalid = rvalid_r[1] & ~rst;
  assign bus.m0_rdata  = bus.mem_rdata;
  assign bus.m1_rdata  = bus.mem_rdata;

  assign bus.mem_en    = |gnt_s;
  assign bus.mem_we    = sel_we_s;
  assign bus.mem_addr  = sel_addr_s;
  assign bus.mem_wdata = sel_wdata_s;
  assign bus.mem_be    = sel_be_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed-vector bench for mem_arbiter with a bench-side
// memory, an abstract arbitration/memory model checked every cycle, and
// hand-computed literal checks along the directed sequence.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic load;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int idx);
    logic [7:0] b;
    b = 8'(idx * 4);
    if (idx == 4)       return 32'hDEADBEEF;
    else if (idx == 12) return 32'hAABBCCDD;
    else                return {b, b, b, b};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  // Bench memory: synchronous single port behind the arbiter.
  logic [31:0] ram [0:255];
  initial begin
    forever begin
      @(posedge clk);
      if (load) begin
        for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        bus.mem_rdata <= 32'd0;
      end else if (bus.mem_en) begin
        if (bus.mem_we) begin
          for (int b = 0; b < 4; b++)
            if (bus.mem_be[b]) ram[bus.mem_addr[9:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end else begin
          bus.mem_rdata <= ram[bus.mem_addr[9:2]];
        end
      end
    end
  end

  // Abstract model: who owns the memory, who was granted last, which read
  // is outstanding, and what the memory must contain.
  initial begin
    int          owner, lastg, pend, eg;
    logic [31:0] pend_data;
    logic [31:0] mmem [0:255];
    logic        r0, r1, lk;
    mem_req_t    rq;
    owner = -1; lastg = 1; pend = -1; pend_data = 32'd0;
    forever begin
      @(negedge clk);
      if (load) begin
        for (int i = 0; i < 256; i++) mmem[i] = init_word(i);
        owner = -1; lastg = 1; pend = -1;
      end else begin
        r0 = bus.m0_req; r1 = bus.m1_req;
        if (rst) eg = -1;
        else if (owner == 0) eg = r0 ? 0 : -1;
        else if (owner == 1) eg = r1 ? 1 : -1;
        else if (r0 && r1) eg = RR ? ((lastg == 0) ? 1 : 0) : 0;
        else if (r0) eg = 0;
        else if (r1) eg = 1;
        else eg = -1;

        chk1("m0_gnt", bus.m0_gnt, eg == 0);
        chk1("m1_gnt", bus.m1_gnt, eg == 1);
        chk1("mem_en", bus.mem_en, eg >= 0);
        chk1("m0_rvalid", bus.m0_rvalid, !rst && pend == 0);
        chk1("m1_rvalid", bus.m1_rvalid, !rst && pend == 1);
        if (!rst && pend == 0) chk("m0_rdata", bus.m0_rdata, pend_data);
        if (!rst && pend == 1) chk("m1_rdata", bus.m1_rdata, pend_data);

        if (eg == 0) begin
          rq = '{we: bus.m0_we, addr: bus.m0_addr, wdata: bus.m0_wdata, be: bus.m0_be};
          lk = bus.m0_lock;
        end else begin
          rq = '{we: bus.m1_we, addr: bus.m1_addr, wdata: bus.m1_wdata, be: bus.m1_be};
          lk = bus.m1_lock;
        end
        if (eg >= 0) begin
          chk1("mem_we", bus.mem_we, rq.we);
          chk("mem_addr", bus.mem_addr, rq.addr);
          chk("mem_wdata", bus.mem_wdata, rq.wdata);
          chk("mem_be", {28'd0, bus.mem_be}, {28'd0, rq.be});
        end

        // Advance the model to the next cycle.
        if (rst) begin
          owner = -1; lastg = 1; pend = -1;
        end else if (eg >= 0) begin
          pend      = rq.we ? -1 : eg;
          pend_data = mmem[rq.addr[9:2]];
          if (rq.we)
            for (int b = 0; b < 4; b++)
              if (rq.be[b]) mmem[rq.addr[9:2]][8*b +: 8] = rq.wdata[8*b +: 8];
          lastg = eg;
          owner = lk ? eg : -1;
        end else begin
          pend = -1;
          if (owner == 0 && !r0) owner = -1;
          if (owner == 1 && !r1) owner = -1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic m0set(input logic req, input logic lock, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    bus.m0_req = req; bus.m0_lock = lock; bus.m0_we = we;
    bus.m0_addr = addr; bus.m0_wdata = wdata; bus.m0_be = be;
  endtask

  task automatic m1set(input logic req, input logic lock, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    bus.m1_req = req; bus.m1_lock = lock; bus.m1_we = we;
    bus.m1_addr = addr; bus.m1_wdata = wdata; bus.m1_be = be;
  endtask

  // Directed sequence with literal expectations.
  initial begin
    logic [2:0] tie_m0;
    tie_m0 = RR ? 3'b101 : 3'b111;
    load = 1'b1; rst = 1'b1;
    m0set(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    m1set(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(negedge clk);
    chk1("rst_m0_gnt", bus.m0_gnt, 1'b0);
    chk1("rst_mem_en", bus.mem_en, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk1("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
    tick; load = 1'b0; rst = 1'b0;

    // Single read.
    m0set(1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'hF);
    @(negedge clk);
    chk1("single_gnt", bus.m0_gnt, 1'b1);
    chk("single_addr", bus.mem_addr, 32'h10);
    tick; m0set(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 4'hF);
    @(negedge clk);
    chk1("single_rvalid", bus.m0_rvalid, 1'b1);
    chk("single_rdata", bus.m0_rdata, 32'hDEADBEEF);
    chk1("single_m1_rvalid", bus.m1_rvalid, 1'b0);

    // Tie from a fresh reset.
    tick; rst = 1'b1;
    tick; rst = 1'b0;
    m0set(1'b1, 1'b0, 1'b0, 32'h10, 32'd0, 4'hF);
    m1set(1'b1, 1'b0, 1'b0, 32'h14, 32'd0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("tie_m0_gnt", bus.m0_gnt, tie_m0[2-k]);
      chk1("tie_m1_gnt", bus.m1_gnt, !tie_m0[2-k]);
      tick;
    end
    m0set(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 4'hF);
    @(negedge clk);
    chk1("tie_m1_alone", bus.m1_gnt, 1'b1);
    tick; m1set(1'b0, 1'b0, 1'b0, 32'h14, 32'd0, 4'hF);

    // Locked multi-beat write by m1 while m0 waits.
    m1set(1'b1, 1'b1, 1'b1, 32'h20, 32'h01010101, 4'hF);
    @(negedge clk);
    chk1("lock_b1_m1", bus.m1_gnt, 1'b1);
    tick;
    m1set(1'b1, 1'b1, 1'b1, 32'h24, 32'h02020202, 4'hF);
    m0set(1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 4'hF);
    @(negedge clk);
    chk1("lock_b2_m0", bus.m0_gnt, 1'b0);
    tick;
    m1set(1'b1, 1'b0, 1'b1, 32'h28, 32'h03030303, 4'hF);
    @(negedge clk);
    chk1("lock_b3_m0", bus.m0_gnt, 1'b0);
    chk1("lock_b3_m1", bus.m1_gnt, 1'b1);
    tick; m1set(1'b0, 1'b0, 1'b0, 32'h28, 32'd0, 4'hF);
    @(negedge clk);
    chk1("lock_after_m0", bus.m0_gnt, 1'b1);
    tick;

    // Byte write then read-back.
    m0set(1'b1, 1'b0, 1'b1, 32'h30, 32'h11223344, 4'b0010);
    @(negedge clk);
    chk("byte_be", {28'd0, bus.mem_be}, 32'h2);
    chk1("byte_we", bus.mem_we, 1'b1);
    tick; m0set(1'b1, 1'b0, 1'b0, 32'h30, 32'd0, 4'hF);
    tick; m0set(1'b0, 1'b0, 1'b0, 32'h30, 32'd0, 4'hF);
    @(negedge clk);
    chk("byte_readback", bus.m0_rdata, 32'hAABB33DD);
    tick;

    // Reset in the cycle after a locked m1 read; write during reset is dropped.
    m1set(1'b1, 1'b1, 1'b0, 32'h14, 32'd0, 4'hF);
    @(negedge clk);
    chk1("rstmid_gnt", bus.m1_gnt, 1'b1);
    tick; rst = 1'b1;
    m1set(1'b0, 1'b0, 1'b0, 32'h14, 32'd0, 4'hF);
    m0set(1'b1, 1'b0, 1'b1, 32'h40, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    chk1("rstmid_rvalid", bus.m1_rvalid, 1'b0);
    chk1("rstmid_mem_en", bus.mem_en, 1'b0);
    tick; rst = 1'b0;
    m0set(1'b1, 1'b0, 1'b0, 32'h40, 32'd0, 4'hF);
    @(negedge clk);
    chk1("rstmid_lock_gone", bus.m0_gnt, 1'b1);
    tick; m0set(1'b0, 1'b0, 1'b0, 32'h40, 32'd0, 4'hF);
    m1set(1'b1, 1'b0, 1'b0, 32'h14, 32'd0, 4'hF);
    @(negedge clk);
    chk("rstmid_no_write", bus.m0_rdata, 32'h40404040);
    chk1("rstmid_m1_gnt", bus.m1_gnt, 1'b1);
    tick; m1set(1'b0, 1'b0, 1'b0, 32'h14, 32'd0, 4'hF);
    @(negedge clk);
    chk("rstmid_m1_rdata", bus.m1_rdata, 32'h14141414);
    tick;

    // Lock released without an access.
    m0set(1'b1, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
    @(negedge clk);
    chk1("rel_own0", bus.m0_gnt, 1'b1);
    tick; m0set(1'b0, 1'b0, 1'b0, 32'h10, 32'd0, 4'hF);
    m1set(1'b1, 1'b0, 1'b0, 32'h18, 32'd0, 4'hF);
    @(negedge clk);
    chk1("rel_blocked", bus.m1_gnt, 1'b0);
    chk1("rel_no_en", bus.mem_en, 1'b0);
    tick;
    @(negedge clk);
    chk1("rel_m1_gnt", bus.m1_gnt, 1'b1);
    tick; m1set(1'b0, 1'b0, 1'b0, 32'h18, 32'd0, 4'hF);
    tick; tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
